// File: rtl/trace_serialiser_if.sv
// Byte-stream channel from the trace serialiser to its sink.
// The master drives data/valid; the slave returns ready.
interface trace_serialiser_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/trace_serialiser.sv
// Buffers fixed-width trace records and emits each as a frame: header byte,
// record bytes LSB first, XOR checksum; an end marker follows once the source locks.
module trace_serialiser #(
    parameter int unsigned RECORD_BYTES = 12,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5,
    parameter logic [7:0]  END_BYTE     = 8'h5A
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trace_valid_i,
    input  logic [RECORD_BYTES*8-1:0]     trace_data_i,
    input  logic                          trace_capture_enable_i,
    input  logic                          lock_i,
    trace_serialiser_if.master            tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [15:0]                   overflow_count_o,
    output logic                          done_o
);

    localparam int unsigned RW = RECORD_BYTES * 8;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IW = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(RECORD_BYTES - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_BODY = 3'd2,
        ST_CSUM = 3'd3,
        ST_END  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic is_tx_state(input state_e s);
        return (s == ST_HDR) || (s == ST_BODY) || (s == ST_CSUM) || (s == ST_END);
    endfunction

    function automatic logic is_capture_state(input state_e s);
        return (s == ST_IDLE) || (s == ST_HDR) || (s == ST_BODY) || (s == ST_CSUM);
    endfunction

    state_e            state_q, state_d;
    logic [RW-1:0]     shift_q, shift_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [15:0]       ovf_q, ovf_d;
    logic              lock_seen_q, lock_seen_d;
    logic              done_q, done_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [RW-1:0]     mem_q [FIFO_DEPTH];

    logic              attempt_s;
    logic              push_s;
    logic              drop_s;
    logic              pop_s;
    logic              empty_s;
    logic              full_s;
    logic [RW-1:0]     head_s;

    assign empty_s = (level_q == {LW{1'b0}});
    assign full_s  = (level_q == FULL_LVL);
    assign head_s  = mem_q[rd_ptr_q];

    // Record storage; contents are only meaningful below the level count.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= trace_data_i;
        end
    end

    // Buffer bookkeeping: full is judged on the registered level, before any pop.
    always_comb begin
        attempt_s   = trace_valid_i & trace_capture_enable_i & is_capture_state(state_q);
        push_s      = attempt_s & ~full_s;
        drop_s      = attempt_s & full_s;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ovf_d       = ovf_q;
        lock_seen_d = lock_seen_q | lock_i;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (drop_s && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end else begin
            ovf_d = ovf_q;
        end
        level_d = level_q + LW'(push_s) - LW'(pop_s);
    end

    // Frame sequencer next state and datapath; every advance is gated by tx_ready.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        done_d  = done_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    csum_d  = 8'h00;
                    state_d = ST_HDR;
                end else if (lock_seen_q) begin
                    state_d = ST_END;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (tx.tx_ready) begin
                    idx_d   = {IW{1'b0}};
                    state_d = ST_BODY;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_BODY: begin
                if (tx.tx_ready) begin
                    csum_d  = csum_fold(csum_q, shift_q[7:0]);
                    shift_d = {8'h00, shift_q[RW-1:8]};
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CSUM;
                    end else begin
                        idx_d   = idx_q + IW'(1'b1);
                        state_d = ST_BODY;
                    end
                end else begin
                    state_d = ST_BODY;
                end
            end
            ST_CSUM: begin
                if (tx.tx_ready) begin
                    // Chain straight into the next header so frames run back to back.
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = head_s;
                        csum_d  = 8'h00;
                        state_d = ST_HDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
            ST_END: begin
                if (tx.tx_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_END;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so the byte lines come straight off flops.
    always_comb begin
        tx_valid_d = is_tx_state(state_d);
        tx_data_d  = 8'h00;
        case (state_d)
            ST_HDR:  tx_data_d = HDR_BYTE;
            ST_BODY: tx_data_d = shift_d[7:0];
            ST_CSUM: tx_data_d = csum_d;
            ST_END:  tx_data_d = END_BYTE;
            default: tx_data_d = 8'h00;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= {RW{1'b0}};
            idx_q       <= {IW{1'b0}};
            csum_q      <= 8'h00;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            level_q     <= {LW{1'b0}};
            ovf_q       <= 16'h0000;
            lock_seen_q <= 1'b0;
            done_q      <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            lock_seen_q <= lock_seen_d;
            done_q      <= done_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign tx.tx_data       = tx_data_q;
    assign tx.tx_valid      = tx_valid_q;
    assign fifo_level_o     = level_q;
    assign overflow_count_o = ovf_q;
    assign done_o           = done_q;

endmodule

// File: tb/tb_trace_serialiser.sv
// Bench for trace_serialiser: a frame-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_trace_serialiser;
    localparam int RB    = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tv  = 1'b0;
    logic [31:0] td  = 32'h0;
    logic        tce = 1'b0;
    logic        lk  = 1'b0;
    logic        rdy = 1'b0;
    logic [2:0]  level;
    logic [15:0] ovf;
    logic        done;

    trace_serialiser_if tx_if();
    assign tx_if.tx_ready = rdy;

    trace_serialiser #(
        .RECORD_BYTES(RB), .FIFO_DEPTH(DEPTH), .HDR_BYTE(8'hA5), .END_BYTE(8'h5A)
    ) dut (
        .clk(clk), .rst(rst), .trace_valid_i(tv), .trace_data_i(td),
        .trace_capture_enable_i(tce), .lock_i(lk), .tx(tx_if),
        .fifo_level_o(level), .overflow_count_o(ovf), .done_o(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: records waiting, bytes of the frame being sent, counters.
    logic [31:0] m_fifo[$];
    logic [7:0]  m_frame[$];
    int unsigned m_ovf  = 0;
    bit          m_lock = 1'b0;
    bit          m_end  = 1'b0;
    bit          m_done = 1'b0;
    bit          live   = 1'b0;

    task automatic load_frame();
        logic [31:0] r;
        logic [7:0]  c;
        r = m_fifo.pop_front();
        c = 8'h00;
        m_frame.push_back(8'hA5);
        for (int i = 0; i < RB; i++) begin
            m_frame.push_back(r[8*i +: 8]);
            c ^= r[8*i +: 8];
        end
        m_frame.push_back(c);
    endtask

    task automatic model_step();
        bit idle_start;
        bit attempt;
        int pre;
        if (rst) begin
            m_fifo.delete();
            m_frame.delete();
            m_ovf  = 0;
            m_lock = 1'b0;
            m_end  = 1'b0;
            m_done = 1'b0;
            live   = 1'b1;
        end else begin
            idle_start = (m_frame.size() == 0);
            attempt    = tv && tce && !m_end;
            pre        = m_fifo.size();
            if (idle_start) begin
                if (!m_end && pre > 0) load_frame();
                else if (!m_end && m_lock) begin
                    m_frame.push_back(8'h5A);
                    m_end = 1'b1;
                end
            end else if (rdy) begin
                void'(m_frame.pop_front());
                if (m_frame.size() == 0) begin
                    if (m_end) m_done = 1'b1;
                    else if (pre > 0) load_frame();
                end
            end
            if (attempt) begin
                if (pre < DEPTH) m_fifo.push_back(td);
                else if (m_ovf < 65535) m_ovf++;
            end
            if (lk) m_lock = 1'b1;
        end
    endtask

    always @(posedge clk) model_step();

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (live) begin
            chk("m_valid", {31'h0, tx_if.tx_valid}, {31'h0, m_frame.size() != 0});
            if (m_frame.size() != 0) chk("m_data", {24'h0, tx_if.tx_data}, {24'h0, m_frame[0]});
            chk("m_level", {29'h0, level}, m_fifo.size());
            chk("m_ovf", {16'h0, ovf}, m_ovf);
            chk("m_done", {31'h0, done}, {31'h0, m_done});
        end
    end

    task automatic rst_seq();
        @(negedge clk);
        rst = 1'b1; tv = 1'b0; tce = 1'b0; lk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", {31'h0, tx_if.tx_valid}, 32'h0);
        chk("rst_data", {24'h0, tx_if.tx_data}, 32'h0);
        chk("rst_level", {29'h0, level}, 32'h0);
        chk("rst_ovf", {16'h0, ovf}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        logic [47:0] seq;
        int n;
        seq = 48'h44_44_33_22_11_A5;

        // Single frame and first-byte latency.
        rst_seq();
        rdy = 1'b1;
        @(negedge clk); tv = 1'b1; tce = 1'b1; td = 32'h44332211;
        @(negedge clk); tv = 1'b0;
        chk("lat_c1_valid", {31'h0, tx_if.tx_valid}, 32'h0);
        chk("lat_c1_level", {29'h0, level}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("frame_valid", {31'h0, tx_if.tx_valid}, 32'h1);
            chk("frame_byte", {24'h0, tx_if.tx_data}, {24'h0, seq[8*i +: 8]});
        end
        @(negedge clk);
        chk("frame_end_valid", {31'h0, tx_if.tx_valid}, 32'h0);
        chk("frame_end_level", {29'h0, level}, 32'h0);

        // Stall in the middle of the body.
        @(negedge clk); tv = 1'b1; td = 32'h44332211;
        @(negedge clk); tv = 1'b0;
        repeat (4) @(negedge clk);
        chk("stall_pre", {24'h0, tx_if.tx_data}, 32'h33);
        rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_hold_data", {24'h0, tx_if.tx_data}, 32'h33);
            chk("stall_hold_valid", {31'h0, tx_if.tx_valid}, 32'h1);
        end
        rdy = 1'b1;
        @(negedge clk); chk("stall_resume1", {24'h0, tx_if.tx_data}, 32'h44);
        @(negedge clk); chk("stall_csum", {24'h0, tx_if.tx_data}, 32'h44);
        @(negedge clk); chk("stall_idle", {31'h0, tx_if.tx_valid}, 32'h0);

        // Six pushes while the sink is stalled: five kept, one dropped.
        rst_seq();
        rdy = 1'b0; tce = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); tv = 1'b1; td = 32'h1000_0000 + 32'(i * 32'h0101_0101);
        end
        @(negedge clk); tv = 1'b0;
        chk("burst_level", {29'h0, level}, 32'd4);
        chk("burst_ovf", {16'h0, ovf}, 32'd1);
        chk("burst_hdr", {24'h0, tx_if.tx_data}, 32'hA5);
        rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            chk("b2b_valid", {31'h0, tx_if.tx_valid}, 32'h1);
            @(negedge clk);
        end
        chk("b2b_after", {31'h0, tx_if.tx_valid}, 32'h0);
        chk("b2b_level", {29'h0, level}, 32'h0);

        // Randomised traffic with varying sink back-pressure.
        rst_seq();
        for (int blk = 0; blk < 15; blk++) begin
            int pct;
            pct = $urandom_range(100, 5);
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                tv  = ($urandom % 3) != 0;
                tce = ($urandom % 8) != 0;
                td  = $urandom;
                rdy = ($urandom % 100) < pct;
            end
        end
        @(negedge clk); tv = 1'b0; rdy = 1'b1;
        repeat (60) @(negedge clk);

        // Reset in the middle of a frame, then a fresh frame.
        tce = 1'b1;
        tv = 1'b1; td = 32'h44332211;
        @(negedge clk); tv = 1'b0;
        @(negedge clk);
        @(negedge clk); tv = 1'b1; td = 32'hDEADBEEF;
        @(negedge clk); tv = 1'b0;
        chk("mid_body", {24'h0, tx_if.tx_data}, 32'h22);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid_rst_valid", {31'h0, tx_if.tx_valid}, 32'h0);
        chk("mid_rst_level", {29'h0, level}, 32'h0);
        chk("mid_rst_ovf", {16'h0, ovf}, 32'h0);
        tv = 1'b1; td = 32'h44332211;
        @(negedge clk); tv = 1'b0;
        @(negedge clk); chk("fresh_hdr", {24'h0, tx_if.tx_data}, 32'hA5);
        @(negedge clk); chk("fresh_b0", {24'h0, tx_if.tx_data}, 32'h11);
        repeat (10) @(negedge clk);

        // Lock with two buffered records: both frames, then end marker, then done.
        rdy = 1'b0;
        tv = 1'b1; td = 32'hCAFE0001;
        @(negedge clk); td = 32'h0BADF00D;
        @(negedge clk); tv = 1'b0; lk = 1'b1;
        @(negedge clk); lk = 1'b0; rdy = 1'b1;
        n = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (tx_if.tx_valid && rdy) n++;
            @(negedge clk);
        end
        chk("lock_done", {31'h0, done}, 32'h1);
        chk("lock_bytes", n, 32'd13);
        tv = 1'b1;
        repeat (10) @(negedge clk);
        tv = 1'b0;
        chk("lock_ignore_ovf", {16'h0, ovf}, 32'h0);
        chk("lock_ignore_level", {29'h0, level}, 32'h0);
        chk("lock_done_hold", {31'h0, done}, 32'h1);
        chk("lock_idle", {31'h0, tx_if.tx_valid}, 32'h0);

        // Saturation of the drop counter.
        rst_seq();
        rdy = 1'b0; tce = 1'b1; tv = 1'b1; td = 32'h55AA55AA;
        repeat (65545) @(negedge clk);
        tv = 1'b0;
        @(negedge clk);
        chk("sat_ovf", {16'h0, ovf}, 32'hFFFF);
        chk("sat_level", {29'h0, level}, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/trace_serialiser.md
TRACE_SERIALISER -- requirements
Module: trace_serialiser

Interface
REQ-001 The block SHALL provide parameter RECORD_BYTES, default 12, giving the trace record width in bytes.
REQ-002 The block SHALL provide parameter FIFO_DEPTH, default 4 (power of two), giving the record buffer depth.
REQ-003 The block SHALL provide parameter HDR_BYTE, default 8'hA5, as the frame start marker.
REQ-004 The block SHALL provide parameter END_BYTE, default 8'h5A, as the end-of-trace marker.
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 trace_valid  in  1  a trace record is presented this cycle; no ready is returned to the source.
REQ-008 trace_data  in  RECORD_BYTES*8  record; byte 0 is bits [7:0].
REQ-009 trace_capture_enable  in  1  the source's capture-enable qualifier.
REQ-010 lock  in  1  the source has stopped tracing; sampled, then held sticky.
REQ-011 tx_data  out  8  serial byte.
REQ-012 tx_valid  out  1  tx_data is valid.
REQ-013 tx_ready  in  1  the sink accepts a byte when tx_valid and tx_ready are both high.
REQ-014 fifo_level  out  clog2(FIFO_DEPTH)+1  number of buffered records.
REQ-015 overflow_count  out  16  number of dropped records, saturating.
REQ-016 done  out  1  end marker delivered; stays high until reset.

Function
REQ-017 A push SHALL occur when trace_valid and trace_capture_enable are high, the FIFO is not full, and the state is IDLE, HDR, BODY or CSUM.
REQ-018 Full SHALL be evaluated on the registered level before any same-cycle pop, so a push attempt while full is dropped even if a pop occurs that cycle.
REQ-019 A dropped record SHALL increment overflow_count by 1, saturating at 16'hFFFF.
REQ-020 In END or DONE, trace_valid SHALL be ignored and SHALL NOT be counted as dropped.
REQ-021 The FSM SHALL have states IDLE, HDR, BODY, CSUM, END and DONE.
REQ-022 From IDLE with the FIFO non-empty, the FSM SHALL pop the head record into a shift register, clear the checksum accumulator, and enter HDR.
REQ-023 From IDLE with the FIFO empty and lock_seen set, the FSM SHALL enter END.
REQ-024 HDR SHALL drive tx_data=HDR_BYTE; on accept it SHALL enter BODY with byte index 0.
REQ-025 BODY SHALL drive record byte[index], sent LSB-byte first; each accept SHALL XOR that byte into the checksum and increment the index.
REQ-026 BODY SHALL enter CSUM on acceptance of byte RECORD_BYTES-1.
REQ-027 CSUM SHALL drive the XOR of all RECORD_BYTES bytes. On accept, the FSM SHALL pop and go straight to HDR if the FIFO is non-empty (zero bubble); otherwise it SHALL go to IDLE.
REQ-028 END SHALL drive tx_data=END_BYTE; on accept it SHALL enter DONE and set done=1.
REQ-029 tx_valid SHALL be high exactly in HDR, BODY, CSUM and END.
REQ-030 While tx_valid is high and tx_ready is low, tx_data and the state SHALL hold unchanged.
REQ-031 Latency: with trace_valid sampled in cycle 0 into an empty FIFO in IDLE, tx_valid=1 with HDR_BYTE SHALL appear in cycle 2.
REQ-032 lock_seen SHALL be set on any cycle with lock=1.
REQ-033 Records already buffered SHALL be fully transmitted before END is entered.
REQ-034 fifo_level SHALL be registered and SHALL reflect the push and pop of the previous edge; a simultaneous push and pop SHALL leave it unchanged.
REQ-035 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-036 Total RTL size SHALL be 120-400 lines.

Reset
REQ-037 With rst=1 at an edge, the block SHALL set state=IDLE, empty the FIFO, set fifo_level=0, overflow_count=0, tx_valid=0, tx_data=0, done=0, and clear lock_seen.
REQ-038 A reset mid-frame SHALL abandon the frame, with tx_valid=0 from the next cycle and no partial continuation.

Verification (RECORD_BYTES=4, FIFO_DEPTH=4, tx_ready=1 unless stated)
REQ-039 Push 32'h44332211 -> tx bytes A5,11,22,33,44,44 on consecutive cycles starting cycle 2; fifo_level returns to 0.
REQ-040 Push 6 records on consecutive cycles with tx_ready=0 -> records 1-5 buffered (1 in shifter plus 4 in FIFO), overflow_count=1; on raising tx_ready, 5 frames go out back-to-back with no idle cycle between a CSUM byte and the next A5.
REQ-041 Hold tx_ready=0 for 10 cycles in BODY index 2 -> tx_data stays 8'h33 and tx_valid stays high; the sequence resumes intact.
REQ-042 Buffer 2 records, pulse lock for 1 cycle -> both frames are sent, then 5A, then done=1; a later trace_valid is ignored and overflow_count is unchanged.
REQ-043 Assert rst during BODY -> next cycle tx_valid=0, fifo_level=0, overflow_count=0; a new push yields a fresh A5 frame.
REQ-044 Force 65540 drops -> overflow_count=16'hFFFF.
